// File: rtl/video_bram_writer_pkg.sv
// rtl/video_bram_writer_pkg.sv - shared types and constants for the video BRAM writer
package video_in_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_FS = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } vbw_state_t;

    localparam logic [3:0] VBW_WEN_FULL  = 4'b1111;
    localparam logic [3:0] VBW_WEN_HI    = 4'b1100;
    localparam logic [3:0] VBW_WEN_NONE  = 4'b0000;

    localparam int VBW_RGB565_W  = 16;
    localparam int VBW_ADDR_STEP = 4;

endpackage

// File: rtl/video_bram_writer_if.sv
// rtl/video_bram_writer_if.sv - BRAM port B bus between the writer and the BRAM block
interface video_bram_writer_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int NUM_WE = 4
) ();

    logic              BRAM_EN_B;
    logic [0:NUM_WE-1] BRAM_WEN_B;
    logic [0:AWIDTH-1] BRAM_Addr_B;
    logic [0:DWIDTH-1] BRAM_Dout_B;
    logic [0:DWIDTH-1] BRAM_Din_B;

    modport master (
        output BRAM_EN_B,
        output BRAM_WEN_B,
        output BRAM_Addr_B,
        output BRAM_Dout_B,
        input  BRAM_Din_B
    );

    modport slave (
        input  BRAM_EN_B,
        input  BRAM_WEN_B,
        input  BRAM_Addr_B,
        input  BRAM_Dout_B,
        output BRAM_Din_B
    );

endinterface

// File: rtl/video_bram_writer_edge.sv
// rtl/video_bram_writer_edge.sv - registered-level edge detector for frame/line valid
module vbw_edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic sig_q;

    // Hold the previous level so the current sample can be compared against it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;
    assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/video_bram_writer.sv
// rtl/video_bram_writer.sv - one-shot frame capture packing pixel pairs into BRAM words
module video_bram_writer
    import video_in_pkg::*;
#(
    parameter int unsigned C_BASEADDR    = 32'h0000,
    parameter int unsigned C_MEMSIZE     = 32'h8000,
    parameter int          C_PORT_DWIDTH = 32,
    parameter int          C_PORT_AWIDTH = 32,
    parameter int          C_NUM_WE      = 4
) (
    input  logic                    BRAM_Clk,
    input  logic                    BRAM_Rst,
    input  logic                    Arm,
    input  logic                    FV_I,
    input  logic                    LV_I,
    input  logic                    Pixel_Valid_I,
    input  logic [0:VBW_RGB565_W-1] Pixel_I,
    video_bram_writer_if.master     bram,
    output logic                    Busy,
    output logic                    Done,
    output logic                    Overflow,
    output logic [0:15]             Word_Count
);

    localparam logic [0:C_PORT_AWIDTH-1] BASE_A    = C_PORT_AWIDTH'(C_BASEADDR);
    localparam logic [0:C_PORT_AWIDTH-1] END_A     = C_PORT_AWIDTH'(C_BASEADDR + C_MEMSIZE);
    localparam logic [0:C_PORT_AWIDTH-1] ADDR_STEP = C_PORT_AWIDTH'(VBW_ADDR_STEP);

    vbw_state_t               state_q;
    logic                     en_q;
    logic [0:C_NUM_WE-1]      wen_q;
    logic [0:C_PORT_AWIDTH-1] addr_q;
    logic [0:C_PORT_DWIDTH-1] dout_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     ovf_q;
    logic [0:15]              wc_q;
    logic                     half_q;

    logic fv_rise;
    logic fv_fall;
    logic lv_rise_unused;
    logic lv_fall;

    logic                accept;
    logic                in_cap;
    logic                wr_full;
    logic                wr_flush;
    logic                wr_fire;
    logic                wr_last;
    logic [0:C_NUM_WE-1] wr_wen;
    logic                din_unused;

    vbw_edge_detect u_fv_edge (
        .clk_i  (BRAM_Clk),
        .rst_i  (BRAM_Rst),
        .sig_i  (FV_I),
        .rise_o (fv_rise),
        .fall_o (fv_fall)
    );

    vbw_edge_detect u_lv_edge (
        .clk_i  (BRAM_Clk),
        .rst_i  (BRAM_Rst),
        .sig_i  (LV_I),
        .rise_o (lv_rise_unused),
        .fall_o (lv_fall)
    );

    // Decide whether this cycle completes a word: a second pixel, or a line/frame end flushing a lone upper half.
    always_comb begin
        accept   = Pixel_Valid_I & FV_I & LV_I;
        in_cap   = (state_q == ST_CAPTURE);
        wr_full  = in_cap & accept & half_q;
        wr_flush = in_cap & half_q & (fv_fall | lv_fall);
        wr_fire  = wr_full | wr_flush;
        wr_wen   = wr_full ? VBW_WEN_FULL : VBW_WEN_HI;
        wr_last  = ((addr_q + ADDR_STEP) == END_A);
    end

    // Capture FSM with packer and address counter; every output comes straight from a register here.
    always_ff @(posedge BRAM_Clk) begin
        if (BRAM_Rst) begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
            wen_q   <= VBW_WEN_NONE;
            addr_q  <= BASE_A;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            wc_q    <= '0;
            half_q  <= 1'b0;
        end else begin
            en_q  <= 1'b0;
            wen_q <= VBW_WEN_NONE;
            // The address steps past a word once its write strobe has been presented.
            if (en_q) begin
                addr_q <= addr_q + ADDR_STEP;
            end
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (Arm) begin
                        state_q <= ST_WAIT_FS;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        wc_q    <= '0;
                        addr_q  <= BASE_A;
                        half_q  <= 1'b0;
                    end
                end
                ST_WAIT_FS: begin
                    if (fv_rise) begin
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (wr_fire) begin
                        en_q   <= 1'b1;
                        wen_q  <= wr_wen;
                        wc_q   <= wc_q + 16'd1;
                        half_q <= 1'b0;
                    end
                    if (wr_full) begin
                        dout_q[16:31] <= Pixel_I;
                    end
                    if (fv_fall) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        ovf_q   <= 1'b0;
                        half_q  <= 1'b0;
                    end else if (wr_fire && wr_last) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        ovf_q   <= 1'b1;
                        half_q  <= 1'b0;
                    end else if (accept && !half_q) begin
                        dout_q[0:15] <= Pixel_I;
                        half_q       <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign din_unused       = ^bram.BRAM_Din_B;
    assign bram.BRAM_EN_B   = en_q;
    assign bram.BRAM_WEN_B  = wen_q;
    assign bram.BRAM_Addr_B = addr_q;
    assign bram.BRAM_Dout_B = dout_q;
    assign Busy             = busy_q;
    assign Done             = done_q;
    assign Overflow         = ovf_q;
    assign Word_Count       = wc_q;

endmodule

// File: tb/tb_video_bram_writer.sv
// tb/tb_video_bram_writer.sv - self-checking bench for video_bram_writer
module tb_video_bram_writer;

    localparam int MEM_A = 32'h8000;
    localparam int MEM_B = 16;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b0;
    logic        fv  = 1'b0;
    logic        lv  = 1'b0;
    logic        pv  = 1'b0;
    logic [15:0] pix = 16'h0;

    logic        busy_a, done_a, ovf_a;
    logic        busy_b, done_b, ovf_b;
    logic [15:0] wc_a, wc_b;

    int ncmp  = 0;
    int nfail = 0;
    int cyc   = 0;

    wr_t obs_a[$];
    wr_t obs_b[$];
    int  bad_a = 0, bad_b = 0;
    int  rise_a = -1, rise_b = -1;
    logic done_a_prev = 1'b0, done_b_prev = 1'b0;

    int base_a, base_b, badb_a, badb_b;

    logic [15:0] px_q[$];
    int          len_q[$];
    int          pcyc_q[$];
    int          lvc_q[$];
    int          fvc;

    video_bram_writer_if #(.AWIDTH(32), .DWIDTH(32), .NUM_WE(4)) bif_a ();
    video_bram_writer_if #(.AWIDTH(32), .DWIDTH(32), .NUM_WE(4)) bif_b ();

    assign bif_a.BRAM_Din_B = 32'hDEAD_BEEF;
    assign bif_b.BRAM_Din_B = 32'h1234_5678;

    video_bram_writer #(.C_BASEADDR(0), .C_MEMSIZE(MEM_A)) dut_a (
        .BRAM_Clk      (clk),
        .BRAM_Rst      (rst),
        .Arm           (arm),
        .FV_I          (fv),
        .LV_I          (lv),
        .Pixel_Valid_I (pv),
        .Pixel_I       (pix),
        .bram          (bif_a),
        .Busy          (busy_a),
        .Done          (done_a),
        .Overflow      (ovf_a),
        .Word_Count    (wc_a)
    );

    video_bram_writer #(.C_BASEADDR(0), .C_MEMSIZE(MEM_B)) dut_b (
        .BRAM_Clk      (clk),
        .BRAM_Rst      (rst),
        .Arm           (arm),
        .FV_I          (fv),
        .LV_I          (lv),
        .Pixel_Valid_I (pv),
        .Pixel_I       (pix),
        .bram          (bif_b),
        .Busy          (busy_b),
        .Done          (done_b),
        .Overflow      (ovf_b),
        .Word_Count    (wc_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bif_a.BRAM_EN_B)
            obs_a.push_back('{addr: bif_a.BRAM_Addr_B, wen: bif_a.BRAM_WEN_B, data: bif_a.BRAM_Dout_B, cyc: cyc});
        if (!bif_a.BRAM_EN_B && bif_a.BRAM_WEN_B != 4'b0000) bad_a = bad_a + 1;
        if (done_a === 1'b1 && done_a_prev !== 1'b1) rise_a = cyc;
        done_a_prev = done_a;
    end

    always @(negedge clk) begin
        if (bif_b.BRAM_EN_B)
            obs_b.push_back('{addr: bif_b.BRAM_Addr_B, wen: bif_b.BRAM_WEN_B, data: bif_b.BRAM_Dout_B, cyc: cyc});
        if (!bif_b.BRAM_EN_B && bif_b.BRAM_WEN_B != 4'b0000) bad_b = bad_b + 1;
        if (done_b === 1'b1 && done_b_prev !== 1'b1) rise_b = cyc;
        done_b_prev = done_b;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_en_a"},   32'(bif_a.BRAM_EN_B),   0);
        chk({tag, "_wen_a"},  32'(bif_a.BRAM_WEN_B),  0);
        chk({tag, "_addr_a"}, bif_a.BRAM_Addr_B,      0);
        chk({tag, "_dout_a"}, bif_a.BRAM_Dout_B,      0);
        chk({tag, "_busy_a"}, 32'(busy_a), 0);
        chk({tag, "_done_a"}, 32'(done_a), 0);
        chk({tag, "_ovf_a"},  32'(ovf_a),  0);
        chk({tag, "_wc_a"},   32'(wc_a),   0);
        chk({tag, "_en_b"},   32'(bif_b.BRAM_EN_B),   0);
        chk({tag, "_wen_b"},  32'(bif_b.BRAM_WEN_B),  0);
        chk({tag, "_addr_b"}, bif_b.BRAM_Addr_B,      0);
        chk({tag, "_dout_b"}, bif_b.BRAM_Dout_B,      0);
        chk({tag, "_busy_b"}, 32'(busy_b), 0);
        chk({tag, "_done_b"}, 32'(done_b), 0);
        chk({tag, "_ovf_b"},  32'(ovf_b),  0);
        chk({tag, "_wc_b"},   32'(wc_b),   0);
    endtask

    task automatic do_arm(input string tag);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        base_a = obs_a.size();
        base_b = obs_b.size();
        badb_a = bad_a;
        badb_b = bad_b;
        chk({tag, "_busy_a"}, 32'(busy_a), 1);
        chk({tag, "_busy_b"}, 32'(busy_b), 1);
    endtask

    task automatic send_frame(input int nlines, input int lmin, input int lmax,
                              input bit gaps, input bit arm_mid, input int first_val);
        int len;
        int idx;
        logic [15:0] v;
        px_q.delete();
        len_q.delete();
        pcyc_q.delete();
        lvc_q.delete();
        idx = 0;
        fv = 1'b1;
        tick();
        tick();
        for (int l = 0; l < nlines; l++) begin
            len = $urandom_range(lmax, lmin);
            lv = 1'b1;
            for (int p = 0; p < len; p++) begin
                if (gaps) begin
                    while ($urandom_range(0, 3) == 0) begin
                        pv = 1'b0;
                        tick();
                        arm = 1'b0;
                    end
                end
                v = (first_val != 0) ? 16'(first_val + idx) : 16'($urandom);
                pv = 1'b1;
                pix = v;
                px_q.push_back(v);
                pcyc_q.push_back(cyc);
                idx++;
                tick();
                arm = 1'b0;
                if (l == 0 && p == 0) arm = arm_mid;
            end
            len_q.push_back(len);
            pv = 1'b0;
            lv = 1'b0;
            lvc_q.push_back(cyc);
            tick();
            arm = 1'b0;
            tick();
        end
        fv = 1'b0;
        fvc = cyc;
        repeat (4) tick();
    endtask

    task automatic check_frame(input int sel, input string tag);
        wr_t exp_q[$];
        wr_t w;
        wr_t g;
        bit  ovf;
        int  limit, k, nwr, nbad, rise, exp_rise;
        logic done_v, ovf_v, busy_v;
        logic [15:0] wc_v;
        logic [31:0] mask;
        limit = (sel == 0) ? MEM_A / 4 : MEM_B / 4;
        ovf = 1'b0;
        k = 0;
        for (int l = 0; l < len_q.size() && !ovf; l++) begin
            for (int j = 0; j < len_q[l] && !ovf; j += 2) begin
                w.addr = 32'(4 * exp_q.size());
                if (j + 1 < len_q[l]) begin
                    w.wen  = 4'b1111;
                    w.data = {px_q[k + j], px_q[k + j + 1]};
                    w.cyc  = pcyc_q[k + j + 1] + 1;
                end else begin
                    w.wen  = 4'b1100;
                    w.data = {px_q[k + j], 16'h0000};
                    w.cyc  = lvc_q[l] + 1;
                end
                exp_q.push_back(w);
                if (exp_q.size() == limit) ovf = 1'b1;
            end
            k += len_q[l];
        end
        if (sel == 0) begin
            nwr = obs_a.size() - base_a; nbad = bad_a - badb_a; rise = rise_a;
            done_v = done_a; ovf_v = ovf_a; busy_v = busy_a; wc_v = wc_a;
        end else begin
            nwr = obs_b.size() - base_b; nbad = bad_b - badb_b; rise = rise_b;
            done_v = done_b; ovf_v = ovf_b; busy_v = busy_b; wc_v = wc_b;
        end
        chk({tag, "_nwrites"}, nwr, exp_q.size());
        for (int i = 0; i < nwr && i < exp_q.size(); i++) begin
            if (sel == 0) g = obs_a[base_a + i];
            else          g = obs_b[base_b + i];
            mask = (exp_q[i].wen == 4'b1111) ? 32'hFFFF_FFFF : 32'hFFFF_0000;
            chk($sformatf("%s_w%0d_addr", tag, i), g.addr, exp_q[i].addr);
            chk($sformatf("%s_w%0d_wen",  tag, i), 32'(g.wen), 32'(exp_q[i].wen));
            chk($sformatf("%s_w%0d_data", tag, i), g.data & mask, exp_q[i].data);
            chk($sformatf("%s_w%0d_cyc",  tag, i), g.cyc, exp_q[i].cyc);
        end
        exp_rise = ovf ? exp_q[exp_q.size() - 1].cyc : fvc + 1;
        chk({tag, "_done"},      32'(done_v), 1);
        chk({tag, "_overflow"},  32'(ovf_v),  32'(ovf));
        chk({tag, "_wordcount"}, 32'(wc_v),   exp_q.size());
        chk({tag, "_busy"},      32'(busy_v), 0);
        chk({tag, "_strobe"},    nbad,        0);
        chk({tag, "_done_cyc"},  rise,        exp_rise);
    endtask

    initial begin
        // reset state
        rst = 1'b1;
        repeat (3) tick();
        chk_reset("reset");
        rst = 1'b0;
        tick();

        // 2 lines x 4 pixels, values 1..8
        do_arm("t1_arm");
        send_frame(2, 4, 4, 1'b0, 1'b0, 1);
        check_frame(0, "t1a");
        check_frame(1, "t1b");
        chk("t1_first_data", (obs_a.size() > base_a) ? obs_a[base_a].data : 32'hx, 32'h0001_0002);
        chk("t1_last_data",  (obs_a.size() > base_a + 3) ? obs_a[base_a + 3].data : 32'hx, 32'h0007_0008);

        // 2 lines x 3 pixels: odd pixel flushed at line end
        do_arm("t2_arm");
        send_frame(2, 3, 3, 1'b0, 1'b0, 1);
        check_frame(0, "t2a");
        check_frame(1, "t2b");
        chk("t2_second_wen", (obs_a.size() > base_a + 1) ? 32'(obs_a[base_a + 1].wen) : 32'hx, 32'hC);
        chk("t2_second_hi",  (obs_a.size() > base_a + 1) ? (obs_a[base_a + 1].data >> 16) : 32'hx, 32'h0003);

        // 12-pixel frame with gaps: small window overflows after 4 words
        do_arm("t3_arm");
        send_frame(2, 6, 6, 1'b1, 1'b0, 0);
        check_frame(0, "t3a");
        check_frame(1, "t3b");

        // arm while a frame is already in progress, then arm again mid-capture
        fv = 1'b1;
        tick();
        tick();
        do_arm("t4_arm");
        lv = 1'b1;
        pv = 1'b1;
        repeat (4) begin
            pix = 16'($urandom);
            tick();
        end
        pv = 1'b0;
        lv = 1'b0;
        tick();
        fv = 1'b0;
        tick();
        tick();
        chk("t4_skip_writes_a", obs_a.size() - base_a, 0);
        chk("t4_skip_writes_b", obs_b.size() - base_b, 0);
        chk("t4_skip_wc_a",     32'(wc_a),   0);
        chk("t4_skip_busy_a",   32'(busy_a), 1);
        chk("t4_skip_done_a",   32'(done_a), 0);
        send_frame(2, 5, 7, 1'b1, 1'b1, 0);
        check_frame(0, "t4a");
        check_frame(1, "t4b");

        // reset mid-line with a half word pending and a completing pixel in the same cycle
        do_arm("t5_arm");
        fv = 1'b1;
        tick();
        tick();
        lv = 1'b1;
        pv = 1'b1;
        pix = 16'hA001; tick();
        pix = 16'hA002; tick();
        pix = 16'hA003; tick();
        pix = 16'hA004;
        rst = 1'b1;
        tick();
        chk_reset("t5_midrst");
        rst = 1'b0;
        pv = 1'b0;
        lv = 1'b0;
        fv = 1'b0;
        tick();
        chk("t5_writes_before_rst", obs_a.size() - base_a, 1);
        chk("t5_idle_busy", 32'(busy_a), 0);
        tick();
        do_arm("t5_rearm");
        send_frame(3, 1, 7, 1'b1, 1'b0, 0);
        check_frame(0, "t5a");
        check_frame(1, "t5b");

        // randomized frames
        for (int f = 0; f < 6; f++) begin
            do_arm($sformatf("r%0d_arm", f));
            send_frame($urandom_range(1, 4), 1, 9, 1'b1, 1'b0, 0);
            check_frame(0, $sformatf("r%0da", f));
            check_frame(1, $sformatf("r%0db", f));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
